// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } icache_state_t;

    localparam int unsigned DEF_NUM_SETS   = 64;
    localparam int unsigned DEF_LINE_WORDS = 4;
    localparam int unsigned XLEN           = 32;
    localparam int unsigned BYTE_OFF_W     = 2;

endpackage

// File: rtl/icache_if.sv
// Line-refill bus between the cache controller (master) and instruction memory (slave).
interface icache_if;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_addr_o,
        input  mem_ready_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o,
        output mem_ready_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/icache_data_array.sv
// Instruction data storage: combinational read for same-cycle hits, synchronous refill write.
module icache_data_array
    import icache_pkg::*;
#(
    parameter int unsigned NUM_SETS   = DEF_NUM_SETS,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
    localparam int unsigned IDX_W     = $clog2(NUM_SETS),
    localparam int unsigned OFF_W     = $clog2(LINE_WORDS)
) (
    input  logic             clk_i,
    input  logic [IDX_W-1:0] rd_set_i,
    input  logic [OFF_W-1:0] rd_word_i,
    output logic [31:0]      rd_data_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_set_i,
    input  logic [OFF_W-1:0] wr_word_i,
    input  logic [31:0]      wr_data_i
);

    logic [31:0] mem_q [NUM_SETS*LINE_WORDS];

    assign rd_data_o = mem_q[{rd_set_i, rd_word_i}];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[{wr_set_i, wr_word_i}] <= wr_data_i;
        end
    end

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped L1 I-cache with miss/refill FSM (IDLE -> REQ -> FILL).
// Optional hit/miss performance counters are built when ICACHE_PERF_CNT_EN is defined.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int unsigned NUM_SETS   = DEF_NUM_SETS,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] pc_fi_i,
    input  logic        fence_i_i,
    output logic [31:0] instr_fi_o,
    output logic        instr_hit_fi_o,
    output logic        ic_repl_permit_o,
    icache_if.master    mem_if,
    output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o
);

    localparam int unsigned OFF_W   = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W   = $clog2(NUM_SETS);
    localparam int unsigned TAG_LSB = IDX_W + OFF_W + BYTE_OFF_W;
    localparam int unsigned TAG_W   = XLEN - TAG_LSB;

    icache_state_t      state_q;
    logic [NUM_SETS-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [NUM_SETS];
    logic [31:0]        line_addr_q;
    logic [OFF_W-1:0]   beat_q;
    logic               mem_req_q;
    logic               permit_q;

    logic [OFF_W-1:0]   pc_word;
    logic [IDX_W-1:0]   pc_idx;
    logic [TAG_W-1:0]   pc_tag;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic [31:0]        line_addr_d;
    logic               lookup_hit;
    logic               miss_start;
    logic               fill_we;
    logic               last_beat;

    assign pc_word     = pc_fi_i[OFF_W+1:2];
    assign pc_idx      = pc_fi_i[TAG_LSB-1:OFF_W+2];
    assign pc_tag      = pc_fi_i[31:TAG_LSB];
    assign fill_idx    = line_addr_q[TAG_LSB-1:OFF_W+2];
    assign fill_tag    = line_addr_q[31:TAG_LSB];
    assign line_addr_d = {pc_fi_i[31:OFF_W+2], {(OFF_W+2){1'b0}}};

    assign lookup_hit = (state_q == IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign miss_start = (state_q == IDLE) && !fence_i_i && !lookup_hit;
    assign fill_we    = (state_q == FILL) && mem_if.mem_rvalid_i && !reset_i;
    assign last_beat  = (beat_q == OFF_W'(LINE_WORDS - 1));

    assign instr_hit_fi_o    = lookup_hit && !reset_i;
    assign ic_repl_permit_o  = permit_q;
    assign mem_if.mem_req_o  = mem_req_q;
    assign mem_if.mem_addr_o = line_addr_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            beat_q      <= '0;
            line_addr_q <= '0;
            mem_req_q   <= 1'b0;
            permit_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fence_i_i) begin
                        valid_q <= '0;
                    end else if (miss_start) begin
                        // The victim line is invalidated now so a partial refill can never hit.
                        line_addr_q     <= line_addr_d;
                        valid_q[pc_idx] <= 1'b0;
                        mem_req_q       <= 1'b1;
                        permit_q        <= 1'b0;
                        state_q         <= REQ;
                    end
                end
                REQ: begin
                    beat_q <= '0;
                    if (mem_if.mem_ready_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= FILL;
                    end
                end
                FILL: begin
                    if (mem_if.mem_rvalid_i) begin
                        beat_q <= beat_q + OFF_W'(1);
                        if (last_beat) begin
                            valid_q[fill_idx] <= 1'b1;
                            permit_q          <= 1'b1;
                            state_q           <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tags are plain storage like the data words; only the valid bits are reset.
    always_ff @(posedge clk_i) begin
        if (fill_we && last_beat) begin
            tag_q[fill_idx] <= fill_tag;
        end
    end

    icache_data_array #(
        .NUM_SETS   (NUM_SETS),
        .LINE_WORDS (LINE_WORDS)
    ) u_data (
        .clk_i     (clk_i),
        .rd_set_i  (pc_idx),
        .rd_word_i (pc_word),
        .rd_data_o (instr_fi_o),
        .we_i      (fill_we),
        .wr_set_i  (fill_idx),
        .wr_word_i (beat_q),
        .wr_data_i (mem_if.mem_rdata_i)
    );

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (lookup_hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_start) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`else
    assign hit_count_o  = '0;
    assign miss_count_o = '0;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed table, hand-written corner sequences, random traffic vs. a line-level model.
module tb_icache_ctrl;

`ifdef ICACHE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_FILL = 2;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic [31:0] pc_fi_i = '0;
    logic        fence_i_i = 1'b0;
    logic [31:0] instr_fi_o;
    logic        instr_hit_fi_o;
    logic        ic_repl_permit_o;
    logic [31:0] hit_count_o;
    logic [31:0] miss_count_o;

    icache_if bus();

    icache_ctrl #(
        .NUM_SETS   (64),
        .LINE_WORDS (4)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .pc_fi_i          (pc_fi_i),
        .fence_i_i        (fence_i_i),
        .instr_fi_o       (instr_fi_o),
        .instr_hit_fi_o   (instr_hit_fi_o),
        .ic_repl_permit_o (ic_repl_permit_o),
        .mem_if           (bus),
        .hit_count_o      (hit_count_o),
        .miss_count_o     (miss_count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: what each set holds, as seen from the line-level rules.
    bit          known = 1'b0;
    int          ph    = P_IDLE;
    int          mbeat = 0;
    logic [31:0] maddr = '0;
    int unsigned mhits = 0;
    int unsigned mmiss = 0;
    bit          mvalid [64];
    logic [21:0] mtag   [64];
    logic [31:0] mdata  [64][4];

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step(input bit rst, input logic [31:0] pc, input bit fence,
                        input bit rdy, input bit rv, input logic [31:0] rd);
        int s;
        int w;
        int ls;
        bit eh;
        @(negedge clk);
        reset_i          = rst;
        pc_fi_i          = pc;
        fence_i_i        = fence;
        bus.mem_ready_i  = rdy;
        bus.mem_rvalid_i = rv;
        bus.mem_rdata_i  = rd;
        #1;
        s  = int'(pc[9:4]);
        w  = int'(pc[3:2]);
        eh = !rst && known && (ph == P_IDLE) && mvalid[s] && (mtag[s] == pc[31:10]);
        chk("hit", 32'(instr_hit_fi_o), 32'(eh));
        if (eh) chk("instr", instr_fi_o, mdata[s][w]);
        if (known) begin
            chk("permit", 32'(ic_repl_permit_o), 32'(ph == P_IDLE));
            chk("mem_req", 32'(bus.mem_req_o), 32'(ph == P_REQ));
            chk("mem_addr", bus.mem_addr_o, maddr);
            chk("hit_cnt", hit_count_o, PERF ? 32'(mhits) : 32'd0);
            chk("miss_cnt", miss_count_o, PERF ? 32'(mmiss) : 32'd0);
        end
        if (rst) begin
            known = 1'b1;
            ph    = P_IDLE;
            mbeat = 0;
            maddr = '0;
            mhits = 0;
            mmiss = 0;
            for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
        end else begin
            case (ph)
                P_IDLE: begin
                    if (eh) mhits++;
                    if (fence) begin
                        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
                    end else if (!eh) begin
                        ph        = P_REQ;
                        maddr     = {pc[31:4], 4'b0000};
                        mvalid[s] = 1'b0;
                        mmiss++;
                    end
                end
                P_REQ: begin
                    if (rdy) begin
                        ph    = P_FILL;
                        mbeat = 0;
                    end
                end
                default: begin
                    if (rv) begin
                        ls = int'(maddr[9:4]);
                        mdata[ls][mbeat] = rd;
                        mbeat++;
                        if (mbeat == 4) begin
                            mvalid[ls] = 1'b1;
                            mtag[ls]   = maddr[31:10];
                            ph         = P_IDLE;
                            $display("[TB] refill of line 0x%08h complete at cycle %0d", maddr, cyc);
                        end
                    end
                end
            endcase
        end
        cyc++;
    endtask

    // Serve the pending refill with an immediate ready and back-to-back beats.
    task automatic run_fill(input logic [31:0] pc);
        for (int i = 0; i < 32 && ph != P_IDLE; i++) begin
            step(1'b0, pc, 1'b0, ph == P_REQ, ph == P_FILL,
                 memword(maddr + 32'(4 * mbeat)));
        end
        if (ph != P_IDLE) begin
            n_tests++;
            n_fail++;
            $display("FAIL fill_timeout: refill of 0x%08h did not finish", maddr);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        bit          rdy;
        bit          rv;
        logic [31:0] rd;
        bit          hit;
        logic [31:0] instr;
        bit          req;
        logic [31:0] addr;
        bit          permit;
        int          hc;
        int          mc;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [31:0] rpc;
        int          beat;

        // Cold miss on 0x104 (set 16, word 1), immediate ready, beats A0..A3, then 6 hits.
        tbl[0]  = '{32'h104, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 0, 0};
        tbl[1]  = '{32'h104, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h100, 1'b0, 0, 1};
        tbl[2]  = '{32'h104, 1'b0, 1'b1, 32'hA0, 1'b0, 32'h0,  1'b0, 32'h100, 1'b0, 0, 1};
        tbl[3]  = '{32'h104, 1'b0, 1'b1, 32'hA1, 1'b0, 32'h0,  1'b0, 32'h100, 1'b0, 0, 1};
        tbl[4]  = '{32'h104, 1'b0, 1'b1, 32'hA2, 1'b0, 32'h0,  1'b0, 32'h100, 1'b0, 0, 1};
        tbl[5]  = '{32'h104, 1'b0, 1'b1, 32'hA3, 1'b0, 32'h0,  1'b0, 32'h100, 1'b0, 0, 1};
        tbl[6]  = '{32'h104, 1'b0, 1'b0, 32'h0,  1'b1, 32'hA1, 1'b0, 32'h100, 1'b1, 0, 1};
        tbl[7]  = '{32'h10C, 1'b0, 1'b0, 32'h0,  1'b1, 32'hA3, 1'b0, 32'h100, 1'b1, 1, 1};
        tbl[8]  = '{32'h108, 1'b0, 1'b0, 32'h0,  1'b1, 32'hA2, 1'b0, 32'h100, 1'b1, 2, 1};
        tbl[9]  = '{32'h100, 1'b0, 1'b0, 32'h0,  1'b1, 32'hA0, 1'b0, 32'h100, 1'b1, 3, 1};
        tbl[10] = '{32'h107, 1'b0, 1'b0, 32'h0,  1'b1, 32'hA1, 1'b0, 32'h100, 1'b1, 4, 1};
        tbl[11] = '{32'h10C, 1'b0, 1'b0, 32'h0,  1'b1, 32'hA3, 1'b0, 32'h100, 1'b1, 5, 1};

        bus.mem_ready_i  = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;

        step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 12; i++) begin
            step(1'b0, tbl[i].pc, 1'b0, tbl[i].rdy, tbl[i].rv, tbl[i].rd);
            chk($sformatf("tbl%0d_hit", i), 32'(instr_hit_fi_o), 32'(tbl[i].hit));
            if (tbl[i].hit) chk($sformatf("tbl%0d_instr", i), instr_fi_o, tbl[i].instr);
            chk($sformatf("tbl%0d_req", i), 32'(bus.mem_req_o), 32'(tbl[i].req));
            chk($sformatf("tbl%0d_addr", i), bus.mem_addr_o, tbl[i].addr);
            chk($sformatf("tbl%0d_permit", i), 32'(ic_repl_permit_o), 32'(tbl[i].permit));
            chk($sformatf("tbl%0d_hitcnt", i), hit_count_o, PERF ? 32'(tbl[i].hc) : 32'd0);
            chk($sformatf("tbl%0d_misscnt", i), miss_count_o, PERF ? 32'(tbl[i].mc) : 32'd0);
        end

        // Slow memory: ready after 3 wait cycles, 2-cycle beat gap -> first hit at T+11.
        beat = 0;
        step(1'b0, 32'h3000, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("slow_t0_hit", 32'(instr_hit_fi_o), 32'd0);
        for (int k = 1; k <= 11; k++) begin
            bit rdy;
            bit rv;
            rdy = (k == 4);
            rv  = (k == 5 || k == 6 || k == 9 || k == 10);
            step(1'b0, 32'h3000, 1'b0, rdy, rv, memword(32'h3000 + 32'(4 * beat)));
            if (rv) beat++;
            chk($sformatf("slow_t%0d_hit", k), 32'(instr_hit_fi_o), 32'(k == 11));
            if (k <= 4) begin
                chk($sformatf("slow_t%0d_req", k), 32'(bus.mem_req_o), 32'd1);
                chk($sformatf("slow_t%0d_addr", k), bus.mem_addr_o, 32'h3000);
            end
        end
        chk("slow_instr", instr_fi_o, memword(32'h3000));

        // Conflict: 0x1100 shares set 16 with 0x100 and evicts it.
        step(1'b0, 32'h1100, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("conf_miss", 32'(instr_hit_fi_o), 32'd0);
        run_fill(32'h1100);
        step(1'b0, 32'h1100, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("conf_hit", 32'(instr_hit_fi_o), 32'd1);
        step(1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("conf_evicted", 32'(instr_hit_fi_o), 32'd0);
        run_fill(32'h100);

        // PC moves to 0x2000 mid-fill: the 0x1100 refill still lands in set 16.
        step(1'b0, 32'h1100, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h1100, 1'b0, 1'b1, 1'b0, 32'h0);
        for (int b = 0; b < 4; b++) begin
            rpc = (b < 2) ? 32'h1100 : 32'h2000;
            step(1'b0, rpc, 1'b0, 1'b0, 1'b1, memword(32'h1100 + 32'(4 * b)));
            chk("midfill_permit", 32'(ic_repl_permit_o), 32'd0);
        end
        step(1'b0, 32'h2000, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("pcchg_new_miss", 32'(instr_hit_fi_o), 32'd0);
        run_fill(32'h2000);
        step(1'b0, 32'h1100, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("pcchg_old_hit", 32'(instr_hit_fi_o), 32'd1);
        chk("pcchg_old_w0", instr_fi_o, memword(32'h1100));
        step(1'b0, 32'h110C, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("pcchg_old_w3", instr_fi_o, memword(32'h110C));

        // Fence: same-cycle hit stands, next cycle misses; then reset during beat 2.
        step(1'b0, 32'h2000, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("fence_same_hit", 32'(instr_hit_fi_o), 32'd1);
        step(1'b0, 32'h2000, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("fence_next_miss", 32'(instr_hit_fi_o), 32'd0);
        step(1'b0, 32'h2000, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'h2000, 1'b0, 1'b0, 1'b1, memword(32'h2000));
        step(1'b0, 32'h2000, 1'b0, 1'b0, 1'b1, memword(32'h2004));
        step(1'b1, 32'h2000, 1'b0, 1'b0, 1'b1, memword(32'h2008));
        chk("rst_hit_low", 32'(instr_hit_fi_o), 32'd0);
        step(1'b0, 32'h2000, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        chk("rst_req", 32'(bus.mem_req_o), 32'd0);
        chk("rst_permit", 32'(ic_repl_permit_o), 32'd1);
        chk("rst_addr", bus.mem_addr_o, 32'h0);
        chk("rst_miss", 32'(instr_hit_fi_o), 32'd0);
        run_fill(32'h2000);
        step(1'b0, 32'h2000, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("rst_refill_hit", 32'(instr_hit_fi_o), 32'd1);
        chk("rst_refill_instr", instr_fi_o, memword(32'h2000));

        // Random traffic: small address pool for reuse, noisy handshakes, rare fence/reset.
        rpc = 32'h0;
        for (int n = 0; n < 2000; n++) begin
            bit          rst;
            bit          fen;
            bit          rdy;
            bit          rv;
            logic [31:0] rd;
            logic [5:0]  idx;
            if ($urandom_range(3) == 0) begin
                case ($urandom_range(3))
                    0: idx = 6'd0;
                    1: idx = 6'd1;
                    2: idx = 6'd16;
                    default: idx = 6'd63;
                endcase
                rpc = {20'h0, 2'($urandom_range(3)), idx, 2'($urandom_range(3)), 2'($urandom_range(3))};
            end
            rst = ($urandom_range(199) == 0);
            fen = ($urandom_range(39) == 0);
            rdy = ($urandom_range(2) != 0);
            rv  = ($urandom_range(2) != 0);
            rd  = (ph == P_FILL) ? memword(maddr + 32'(4 * mbeat)) : $urandom;
            step(rst, rpc, fen, rdy, rv, rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
